slt_share_arbiter: RTL

//  Shares one set-less-than comparator between two requesters: port 0 = ALU
//  SLT/SLTI issue, port 1 = branch/compare unit.

---
 rtl/cpu16_pkg.sv | 41 ++++
 rtl/slt_compare.sv | 20 ++
 rtl/slt_share_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared types and helpers for the 16-bit CPU datapath slice around the
// shared set-less-than unit.
package cpu16_pkg;

  localparam int CPU_W = 16;
  localparam int TAG_W = 4;

  // Request as seen by the shared comparator
  typedef struct packed {
    logic [CPU_W-1:0] a;
    logic [CPU_W-1:0] b;
    logic             signed_cmp;
    logic [TAG_W-1:0] tag;
  } slt_req_t;

  // Response written into the one-entry output register
  typedef struct packed {
    logic [CPU_W-1:0] result;
    logic             id;
    logic [TAG_W-1:0] tag;
  } slt_rsp_t;

  // Output register occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Two-way round-robin pick: a lone valid port wins, ties go to ptr
  function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
    logic [1:0] g;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/slt_compare.sv
// Combinational WIDTH-bit less-than, two's-complement or unsigned.
module slt_compare #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_cmp,
  output logic             lt
);

  // Select the signed or unsigned ordering of the two operands
  always_comb begin
    if (signed_cmp) begin
      lt = ($signed(a) < $signed(b));
    end else begin
      lt = (a < b);
    end
  end

endmodule

// File: rtl/slt_share_arbiter.sv
// Round-robin share of one set-less-than comparator between the ALU SLT
// issue port (0) and the branch/compare unit (1), with a one-entry
// registered response that can drain and refill in the same cycle.
module slt_share_arbiter
  import cpu16_pkg::*;
#(
  parameter int WIDTH   = CPU_W,
  parameter int TAG_W   = cpu16_pkg::TAG_W,
  parameter bit RR_INIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [1:0]           req_signed,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_result,
  output logic                 resp_id,
  output logic [TAG_W-1:0]     resp_tag
);

  out_state_e       state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             can_accept_s;
  logic             both_valid_s;
  logic [1:0]       grant_s;
  logic             win_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             sel_signed_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic             lt_s;

  // Arbitration and handshake: grant depends only on valids and rr_ptr,
  // acceptance additionally on whether the output register frees up
  always_comb begin
    can_accept_s = (state_q == OUT_EMPTY) || resp_ready;
    both_valid_s = &req_valid;
    grant_s      = rr_grant(req_valid, rr_ptr_q);
    win_id_s     = grant_s[1];
    if (rst) begin
      req_ready = 2'b00;
    end else if (can_accept_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
    accept_s = |req_ready;
  end

  // Route the winning requester's operands and tag to the comparator
  always_comb begin
    if (win_id_s) begin
      sel_a_s      = req_a[2*WIDTH-1:WIDTH];
      sel_b_s      = req_b[2*WIDTH-1:WIDTH];
      sel_signed_s = req_signed[1];
      sel_tag_s    = req_tag[2*TAG_W-1:TAG_W];
    end else begin
      sel_a_s      = req_a[WIDTH-1:0];
      sel_b_s      = req_b[WIDTH-1:0];
      sel_signed_s = req_signed[0];
      sel_tag_s    = req_tag[TAG_W-1:0];
    end
  end

  slt_compare #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a          (sel_a_s),
    .b          (sel_b_s),
    .signed_cmp (sel_signed_s),
    .lt         (lt_s)
  );

  // Next state of the output register and the fairness pointer
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
    tag_d    = tag_q;
    if (accept_s) begin
      state_d  = OUT_FULL;
      result_d = {{(WIDTH-1){1'b0}}, lt_s};
      id_d     = win_id_s;
      tag_d    = sel_tag_s;
    end else if ((state_q == OUT_FULL) && resp_ready) begin
      state_d = OUT_EMPTY;
    end else begin
      state_d = state_q;
    end
    // Only a real contest moves the pointer, so a lone requester leaves
    // the other port's turn intact
    if (accept_s && both_valid_s) begin
      rr_ptr_d = ~win_id_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OUT_EMPTY;
      rr_ptr_q <= RR_INIT;
      result_q <= {WIDTH{1'b0}};
      id_q     <= 1'b0;
      tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      result_q <= result_d;
      id_q     <= id_d;
      tag_q    <= tag_d;
    end
  end

  assign resp_valid  = (state_q == OUT_FULL);
  assign resp_result = result_q;
  assign resp_id     = id_q;
  assign resp_tag    = tag_q;

endmodule
